// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter: count controls in, count state out.
interface mod_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             up;
    logic             sat;
    logic [WIDTH-1:0] limit;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             clear_ovf;
    logic [WIDTH-1:0] value;
    logic             tc;
    logic             ovf;

    // Master drives the controls and observes the count.
    modport master (
        output en, up, sat, limit, load, load_value, clear_ovf,
        input  value, tc, ovf
    );

    // Slave is the counter itself.
    modport slave (
        input  en, up, sat, limit, load, load_value, clear_ovf,
        output value, tc, ovf
    );
endinterface

// File: rtl/mod_counter.sv
// Up/down counter with programmable limit, wrap/saturate boundary handling,
// synchronous load, enable prescaler, terminal-count pulse and sticky overflow.
module mod_counter #(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned     PRESCALE    = 1
) (
    input  logic          clk,
    input  logic          reset,
    mod_counter_if.slave  bus
);
    localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] value_q, value_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             fire;
    logic             boundary;
    logic             boundary_step;
    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] load_clamped;

    // Next-state: load beats a step; a boundary step sets ovf even if clear_ovf is high.
    always_comb begin
        fire          = bus.en && (pre_q == PRE_LAST);
        load_clamped  = (bus.load_value > bus.limit) ? bus.limit : bus.load_value;
        // Up boundary uses >= so a value left above a lowered limit still wraps/pins.
        boundary      = bus.up ? (value_q >= bus.limit) : (value_q == '0);
        if (bus.up) begin
            step_value = boundary ? (bus.sat ? bus.limit : '0) : value_q + WIDTH'(1);
        end else begin
            step_value = boundary ? (bus.sat ? '0 : bus.limit) : value_q - WIDTH'(1);
        end

        value_d       = value_q;
        pre_d         = pre_q;
        tc_d          = 1'b0;
        boundary_step = 1'b0;

        if (bus.load) begin
            value_d = load_clamped;
            pre_d   = '0;
        end else if (bus.en) begin
            pre_d = fire ? '0 : pre_q + PW'(1);
            if (fire) begin
                value_d       = step_value;
                boundary_step = boundary;
                tc_d          = boundary;
            end
        end

        ovf_d = boundary_step | (ovf_q & ~bus.clear_ovf);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= RESET_VALUE;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.value = value_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: two instances (PRESCALE=1 / RESET_VALUE=0,
// PRESCALE=3 / RESET_VALUE=0x10). Stimulus pushes expected post-edge state,
// a negedge monitor pops and compares.
module tb_mod_counter;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    mod_counter_if #(.WIDTH(8)) bus_a ();
    mod_counter_if #(.WIDTH(8)) bus_b ();

    mod_counter #(.WIDTH(8), .RESET_VALUE(8'h00), .PRESCALE(1)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    mod_counter #(.WIDTH(8), .RESET_VALUE(8'h10), .PRESCALE(3)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    typedef struct {
        int         dut;
        logic [7:0] v;
        logic       tc;
        logic       ovf;
        string      nm;
    } exp_t;

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    task automatic set_a(input logic r, input logic en, input logic up, input logic sat,
                         input logic [7:0] lim, input logic ld, input logic [7:0] lv,
                         input logic clr);
        rst_a = r; bus_a.en = en; bus_a.up = up; bus_a.sat = sat; bus_a.limit = lim;
        bus_a.load = ld; bus_a.load_value = lv; bus_a.clear_ovf = clr;
    endtask

    task automatic set_b(input logic r, input logic en, input logic up, input logic sat,
                         input logic [7:0] lim, input logic ld, input logic [7:0] lv,
                         input logic clr);
        rst_b = r; bus_b.en = en; bus_b.up = up; bus_b.sat = sat; bus_b.limit = lim;
        bus_b.load = ld; bus_b.load_value = lv; bus_b.clear_ovf = clr;
    endtask

    // Apply current inputs at one edge, then queue the state expected after it.
    task automatic cyc(input int d, input logic [7:0] v, input logic t, input logic o,
                       input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.dut = d; e.v = v; e.tc = t; e.ovf = o; e.nm = nm;
        sbq.push_back(e);
    endtask

    // Monitor: compare every queued expectation against the selected instance.
    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] act;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = (e.dut == 0) ? {bus_a.value, bus_a.tc, bus_a.ovf}
                               : {bus_b.value, bus_b.tc, bus_b.ovf};
            n_total++;
            if (act === {e.v, e.tc, e.ovf}) begin
                n_pass++;
            end else begin
                n_fail++;
                $display("FAIL %s: got value=%02h tc=%0b ovf=%0b, want value=%02h tc=%0b ovf=%0b",
                         e.nm, act[9:2], act[1], act[0], e.v, e.tc, e.ovf);
            end
        end
    end

    initial begin
        set_a(1, 0, 1, 0, 8'hFF, 0, 8'h00, 0);
        set_b(1, 1, 1, 0, 8'hFF, 1, 8'h55, 0);

        // Instance A: reset, then free-running wrap through FF -> 00.
        cyc(0, 8'h00, 0, 0, "reset");
        cyc(0, 8'h00, 0, 0, "reset_hold");
        set_a(0, 1, 1, 0, 8'hFF, 0, 8'h00, 0);
        for (int k = 1; k <= 257; k++) begin
            cyc(0, 8'(k), (k == 256), (k >= 256), "wrap_up");
        end
        set_a(0, 0, 1, 0, 8'hFF, 0, 8'h00, 1);
        cyc(0, 8'h01, 0, 0, "clear_ovf");

        // Load beats en; then down with wrap at limit 5.
        set_a(0, 1, 0, 0, 8'h05, 1, 8'h02, 0);
        cyc(0, 8'h02, 0, 0, "load_en_prio");
        set_a(0, 1, 0, 0, 8'h05, 0, 8'h00, 0);
        cyc(0, 8'h01, 0, 0, "down");
        cyc(0, 8'h00, 0, 0, "down");
        cyc(0, 8'h05, 1, 1, "down_wrap");
        cyc(0, 8'h04, 0, 1, "down_after_wrap");
        set_a(0, 0, 0, 0, 8'h05, 1, 8'h09, 0);
        cyc(0, 8'h05, 0, 1, "load_clamp");

        // Saturate up at limit 10.
        set_a(0, 0, 1, 1, 8'h0A, 1, 8'h08, 1);
        cyc(0, 8'h08, 0, 0, "load_clr");
        set_a(0, 1, 1, 1, 8'h0A, 0, 8'h00, 0);
        cyc(0, 8'h09, 0, 0, "sat_up");
        cyc(0, 8'h0A, 0, 0, "sat_reach");
        cyc(0, 8'h0A, 1, 1, "sat_pin");
        cyc(0, 8'h0A, 1, 1, "sat_pin2");
        set_a(0, 1, 1, 1, 8'h0A, 0, 8'h00, 1);
        cyc(0, 8'h0A, 1, 1, "set_wins");
        set_a(0, 0, 1, 1, 8'h0A, 0, 8'h00, 0);
        cyc(0, 8'h0A, 0, 1, "ovf_sticky");
        set_a(0, 0, 1, 1, 8'h0A, 0, 8'h00, 1);
        cyc(0, 8'h0A, 0, 0, "ovf_cleared");

        // Value above a lowered limit: down decrements, up is a boundary.
        set_a(0, 0, 1, 0, 8'hFF, 1, 8'hC8, 0);
        cyc(0, 8'hC8, 0, 0, "load_c8");
        set_a(0, 1, 0, 0, 8'h05, 0, 8'h00, 0);
        cyc(0, 8'hC7, 0, 0, "down_above_limit");
        set_a(0, 1, 1, 0, 8'h05, 0, 8'h00, 0);
        cyc(0, 8'h00, 1, 1, "up_above_limit");

        // Reset beats load and en.
        set_a(1, 1, 1, 0, 8'hFF, 1, 8'h37, 0);
        cyc(0, 8'h00, 0, 0, "reset_prio");

        // limit = 0: every step is a boundary.
        set_a(0, 1, 1, 0, 8'h00, 0, 8'h00, 0);
        cyc(0, 8'h00, 1, 1, "lim0_up");
        set_a(0, 1, 0, 0, 8'h00, 0, 8'h00, 0);
        cyc(0, 8'h00, 1, 1, "lim0_down");
        set_a(0, 1, 1, 1, 8'h00, 0, 8'h00, 0);
        cyc(0, 8'h00, 1, 1, "lim0_sat");
        set_a(0, 0, 1, 0, 8'h00, 0, 8'h00, 0);
        cyc(0, 8'h00, 0, 1, "lim0_idle");

        // Instance B: reset with load+en, RESET_VALUE 0x10.
        cyc(1, 8'h10, 0, 0, "b_reset_prio");
        // en pattern 1,1,0,1,1,1,1 -> steps on 3rd and 6th enabled cycles.
        set_b(0, 1, 1, 0, 8'hFF, 0, 8'h00, 0); cyc(1, 8'h10, 0, 0, "pre_en1");
        cyc(1, 8'h10, 0, 0, "pre_en2");
        set_b(0, 0, 1, 0, 8'hFF, 0, 8'h00, 0); cyc(1, 8'h10, 0, 0, "pre_frozen");
        set_b(0, 1, 1, 0, 8'hFF, 0, 8'h00, 0); cyc(1, 8'h11, 0, 0, "pre_step1");
        cyc(1, 8'h11, 0, 0, "pre_en4");
        cyc(1, 8'h11, 0, 0, "pre_en5");
        cyc(1, 8'h12, 0, 0, "pre_step2");
        // Load mid-count restarts the spacing.
        cyc(1, 8'h12, 0, 0, "pre_mid1");
        cyc(1, 8'h12, 0, 0, "pre_mid2");
        set_b(0, 1, 1, 0, 8'hFF, 1, 8'h30, 0); cyc(1, 8'h30, 0, 0, "pre_load");
        set_b(0, 1, 1, 0, 8'hFF, 0, 8'h00, 0); cyc(1, 8'h30, 0, 0, "pre_after_load1");
        cyc(1, 8'h30, 0, 0, "pre_after_load2");
        cyc(1, 8'h31, 0, 0, "pre_after_load3");
        // Reset while value is 0x37.
        set_b(0, 0, 1, 0, 8'hFF, 1, 8'h37, 0); cyc(1, 8'h37, 0, 0, "b_load37");
        set_b(1, 1, 1, 0, 8'hFF, 0, 8'h00, 0); cyc(1, 8'h10, 0, 0, "b_reset_mid");
        set_b(0, 0, 1, 0, 8'hFF, 0, 8'h00, 0); cyc(1, 8'h10, 0, 0, "b_after_reset");

        for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_total++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", sbq.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
